sound_sched: RTL

SOUND_SCHED -- requirements
Module: sound_sched

---
 rtl/sound_sched_if.sv | 24 ++
 rtl/sound_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sound_sched_if.sv
// Sound scheduler bus: four level-sensitive sound requests in, the
// registered tone code, tone enable, active source ID and done pulse out.
interface sound_sched_if;
   logic        req_lwin;
   logic        req_rwin;
   logic        req_paddle;
   logic        req_wall;
   logic [11:0] note;
   logic        tone_en;
   logic [1:0]  active_id;
   logic        done;

   // Game logic side: raises requests, listens to the tone generator outputs.
   modport master (
      output req_lwin, req_rwin, req_paddle, req_wall,
      input  note, tone_en, active_id, done
   );

   // Scheduler side.
   modport slave (
      input  req_lwin, req_rwin, req_paddle, req_wall,
      output note, tone_en, active_id, done
   );
endinterface

// File: rtl/sound_sched.sv
// Sound scheduler: arbitrates four sound sources (left win, right win,
// paddle, wall) onto a single tone generator, one note per clk_10Hz tick.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | silent, waiting for a pending request
//   PLAY  | sounding note[step] of source active_id
//   GAP   | one silent tick after a completed sound, done pulse high
//
// Request bit order everywhere: [0]=lwin [1]=rwin [2]=paddle [3]=wall,
// which is also the priority order and the active_id encoding.
module sound_sched #(
   parameter int WIN_LEN  = 29,
   parameter int HIT_LEN  = 2,
   parameter int WALL_LEN = 1
) (
   input  logic         clk_10Hz,
   input  logic         reset,
   sound_sched_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   localparam logic [5:0] WIN_LAST  = 6'(WIN_LEN - 1);
   localparam logic [5:0] HIT_LAST  = 6'(HIT_LEN - 1);
   localparam logic [5:0] WALL_LAST = 6'(WALL_LEN - 1);

   state_t      state_q, state_d;
   logic [3:0]  req_q, req_d;
   logic [3:0]  pend_q, pend_d;
   logic [5:0]  step_q, step_d;
   logic [1:0]  id_q, id_d;
   logic [11:0] note_q, note_d;
   logic        tone_q, tone_d;
   logic        done_q, done_d;

   logic [3:0]  edge_w;
   logic [3:0]  pend_eff;
   logic [1:0]  grant_id;
   logic [1:0]  start_id;
   logic [3:0]  drop_mask;
   logic        start_w;
   logic        preempt_w;

   // Highest-priority set bit; caller guarantees at least one bit is set.
   function automatic logic [1:0] pick(input logic [3:0] p);
      logic [1:0] r;
      if (p[0])      r = 2'd0;
      else if (p[1]) r = 2'd1;
      else if (p[2]) r = 2'd2;
      else           r = 2'd3;
      return r;
   endfunction

   // Tone code for a given source and step. Win melodies walk the mid
   // digit through a 7-note scale, up for lwin and down for rwin.
   function automatic logic [11:0] note_of(input logic [1:0] id,
                                           input logic [5:0] step);
      logic [2:0]  ph;
      logic [11:0] n;
      ph = 3'(step % 6'd7);
      case (id)
         2'd0:    n = {4'h0, 1'b0, 3'(ph + 3'd1), 4'h0};
         2'd1:    n = {4'h0, 1'b0, 3'(3'd7 - ph), 4'h0};
         2'd2:    n = 12'h100;
         default: n = 12'h005;
      endcase
      return n;
   endfunction

   // Index of the final note for each source.
   function automatic logic [5:0] last_of(input logic [1:0] id);
      logic [5:0] l;
      case (id)
         2'd0, 2'd1: l = WIN_LAST;
         2'd2:       l = HIT_LAST;
         default:    l = WALL_LAST;
      endcase
      return l;
   endfunction

   // Edge detect, effective pending and next-state/next-output decode.
   always_comb begin
      req_d     = {bus.req_wall, bus.req_paddle, bus.req_rwin, bus.req_lwin};
      edge_w    = req_d & ~req_q;
      pend_eff  = pend_q | edge_w;
      grant_id  = pick(pend_eff);
      preempt_w = id_q[1] & (|edge_w[1:0]);

      state_d   = state_q;
      pend_d    = pend_eff;
      step_d    = step_q;
      id_d      = id_q;
      note_d    = note_q;
      tone_d    = tone_q;
      done_d    = 1'b0;
      start_w   = 1'b0;
      start_id  = grant_id;
      drop_mask = 4'b0000;

      case (state_q)
         S_IDLE, S_GAP: begin
            if (|pend_eff) begin
               start_w = 1'b1;
            end else begin
               state_d = S_IDLE;
               step_d  = 6'd0;
               note_d  = 12'h000;
               tone_d  = 1'b0;
            end
         end
         S_PLAY: begin
            if (preempt_w) begin
               // A win cuts a paddle/wall sound short; the cut sound is
               // dropped rather than replayed later.
               start_w   = 1'b1;
               start_id  = pick({2'b00, pend_eff[1:0]});
               drop_mask = 4'b0001 << id_q;
            end else if (step_q == last_of(id_q)) begin
               state_d = S_GAP;
               note_d  = 12'h000;
               tone_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               step_d = step_q + 6'd1;
               note_d = note_of(id_q, step_q + 6'd1);
            end
         end
         default: begin
            state_d = S_IDLE;
            note_d  = 12'h000;
            tone_d  = 1'b0;
         end
      endcase

      if (start_w) begin
         state_d = S_PLAY;
         step_d  = 6'd0;
         id_d    = start_id;
         note_d  = note_of(start_id, 6'd0);
         tone_d  = 1'b1;
         pend_d  = pend_eff & ~drop_mask & ~(4'b0001 << start_id);
      end
   end

   // State and registered outputs; request copies reset high so a level
   // held across reset release is not mistaken for a new request.
   always_ff @(posedge clk_10Hz or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         req_q   <= 4'b1111;
         pend_q  <= 4'b0000;
         step_q  <= 6'd0;
         id_q    <= 2'd0;
         note_q  <= 12'h000;
         tone_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         pend_q  <= pend_d;
         step_q  <= step_d;
         id_q    <= id_d;
         note_q  <= note_d;
         tone_q  <= tone_d;
         done_q  <= done_d;
      end
   end

   assign bus.note      = note_q;
   assign bus.tone_en   = tone_q;
   assign bus.active_id = id_q;
   assign bus.done      = done_q;

endmodule
